// File: rtl/exec_unit.sv
// Register-bank execution unit: single-cycle ALU ops plus an iterative
// shift-and-add multiplier, all results written back through registered ports.
module exec_unit #(
  parameter int BITS     = 8,
  parameter int REG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [BITS-1:0]     data_a,
  input  logic [BITS-1:0]     data_b,
  input  logic [REG_BITS-1:0] dest_address,
  output logic                write_enable,
  output logic [REG_BITS-1:0] write_address,
  output logic [BITS-1:0]     write_data,
  output logic                busy,
  output logic                zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int CNT_W = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_reg;
  logic [BITS-1:0]      mcand_reg;
  logic [BITS-1:0]      mplier_reg;
  logic [BITS-1:0]      acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [REG_BITS-1:0]  dest_reg;

  logic [BITS-1:0]      alu_result;
  logic [BITS-1:0]      acc_next;

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = data_a + data_b;
      OP_SUB:  alu_result = data_a - data_b;
      OP_AND:  alu_result = data_a & data_b;
      OP_OR:   alu_result = data_a | data_b;
      OP_XOR:  alu_result = data_a ^ data_b;
      OP_SLTU: alu_result[0] = (data_a < data_b);
      default: alu_result = '0;
    endcase
  end

  // One partial product per iteration; the multiplicand is pre-shifted so
  // the sum stays modulo 2^BITS without a wider accumulator.
  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0])
      acc_next = acc_reg + mcand_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      dest_reg      <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      busy          <= 1'b0;
      zero          <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_reg  <= data_a;
              mplier_reg <= data_b;
              dest_reg   <= dest_address;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              busy       <= 1'b1;
              state_reg  <= S_MUL;
            end else if (op != OP_NOP) begin
              write_enable  <= 1'b1;
              write_data    <= alu_result;
              write_address <= dest_address;
              zero          <= (alu_result == '0);
            end
          end
        end
        S_MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg     <= S_IDLE;
            busy          <= 1'b0;
            write_enable  <= 1'b1;
            write_data    <= acc_next;
            write_address <= dest_reg;
            zero          <= (acc_next == '0);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with BITS=8, REG_BITS=8.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] dest_address;
  logic       write_enable;
  logic [7:0] write_address;
  logic [7:0] write_data;
  logic       busy;
  logic       zero;

  int total = 0;
  int bad   = 0;

  exec_unit #(.BITS(8), .REG_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .data_a       (data_a),
    .data_b       (data_b),
    .dest_address (dest_address),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] d);
    start = s; op = o; data_a = a; data_b = b; dest_address = d;
  endtask

  task automatic check_wb(input string tag, input logic [7:0] wd, input logic [7:0] wa,
                          input logic z);
    $display("txn %s: we=%0b wd=%h wa=%h zero=%0b busy=%0b", tag, write_enable,
             write_data, write_address, zero, busy);
    check({tag, "_we"}, 16'(write_enable), 16'(1'b1));
    check({tag, "_wd"}, 16'(write_data), 16'(wd));
    check({tag, "_wa"}, 16'(write_address), 16'(wa));
    check({tag, "_zero"}, 16'(zero), 16'(z));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b111, 8'h00, 8'h00, 8'h00);
    step();
    step();
    check("rst_we", 16'(write_enable), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_zero", 16'(zero), 16'h0);
    check("rst_wd", 16'(write_data), 16'h0);
    check("rst_wa", 16'(write_address), 16'h0);
    rst = 1'b0;

    // ADD with carry discarded
    drive(1'b1, 3'b000, 8'hF0, 8'h20, 8'd3);
    step();
    check_wb("add", 8'h10, 8'd3, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    step();
    check("add_we_drop", 16'(write_enable), 16'h0);
    check("add_wd_hold", 16'(write_data), 16'h10);
    check("add_wa_hold", 16'(write_address), 16'h3);

    // SUB to zero, then SLTU back to back
    drive(1'b1, 3'b001, 8'h05, 8'h05, 8'd1);
    step();
    check_wb("sub", 8'h00, 8'd1, 1'b1);
    drive(1'b1, 3'b101, 8'h01, 8'hFF, 8'd2);
    step();
    check_wb("sltu", 8'h01, 8'd2, 1'b0);
    drive(1'b1, 3'b101, 8'hFF, 8'h01, 8'd2);
    step();
    check_wb("sltu_false", 8'h00, 8'd2, 1'b1);
    drive(1'b1, 3'b010, 8'hF0, 8'h3C, 8'd8);
    step();
    check_wb("and", 8'h30, 8'd8, 1'b0);
    drive(1'b1, 3'b011, 8'hF0, 8'h3C, 8'd9);
    step();
    check_wb("or", 8'hFC, 8'd9, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    step();
    check("idle_we", 16'(write_enable), 16'h0);

    // MUL 0x0D * 0x0B = 0x8F, 8 cycles
    drive(1'b1, 3'b110, 8'h0D, 8'h0B, 8'd7);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    check("mul_busy_0", 16'(busy), 16'h1);
    check("mul_we_0", 16'(write_enable), 16'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("mul_busy_%0d", i), 16'(busy), 16'h1);
      check($sformatf("mul_we_%0d", i), 16'(write_enable), 16'h0);
    end
    step();
    check("mul_busy_end", 16'(busy), 16'h0);
    check_wb("mul", 8'h8F, 8'd7, 1'b0);
    step();
    check("mul_we_drop", 16'(write_enable), 16'h0);

    // MUL with mid-operation starts ignored; start on busy-falling edge accepted
    drive(1'b1, 3'b110, 8'h03, 8'h05, 8'd4);
    step();
    drive(1'b1, 3'b000, 8'hFF, 8'hFF, 8'd9);
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("ign_we_%0d", i), 16'(write_enable), 16'h0);
    end
    drive(1'b1, 3'b000, 8'h01, 8'h02, 8'd5);
    step();
    check("ign_busy_end", 16'(busy), 16'h0);
    check_wb("mul_ign", 8'h0F, 8'd4, 1'b0);
    step();
    check_wb("add_after_mul", 8'h03, 8'd5, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    step();
    check("after_mul_we", 16'(write_enable), 16'h0);

    // MUL wrap to zero: 0x10 * 0x10 = 0x100
    drive(1'b1, 3'b110, 8'h10, 8'h10, 8'd6);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    for (int i = 1; i < 8; i++) step();
    step();
    check_wb("mul_wrap", 8'h00, 8'd6, 1'b1);

    // Reset on 4th MUL cycle aborts with no writeback
    drive(1'b1, 3'b110, 8'h0D, 8'h0B, 8'd6);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_we", 16'(write_enable), 16'h0);
    check("abort_wd", 16'(write_data), 16'h0);
    check("abort_zero", 16'(zero), 16'h0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (write_enable === 1'b1) seen++;
      end
      check("abort_no_wb", 16'(seen), 16'h0);
    end

    // ADD, NOP, XOR consecutive
    drive(1'b1, 3'b000, 8'h01, 8'h02, 8'd1);
    step();
    check_wb("seq_add", 8'h03, 8'd1, 1'b0);
    drive(1'b1, 3'b111, 8'h00, 8'h00, 8'd3);
    step();
    check("seq_nop_we", 16'(write_enable), 16'h0);
    check("seq_nop_wd", 16'(write_data), 16'h03);
    check("seq_nop_wa", 16'(write_address), 16'h01);
    check("seq_nop_busy", 16'(busy), 16'h0);
    drive(1'b1, 3'b100, 8'hAA, 8'hFF, 8'd2);
    step();
    check_wb("seq_xor", 8'h55, 8'd2, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'd0);
    step();
    check("seq_end_we", 16'(write_enable), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter BITS, default 8, datapath width of operands and result.
REQ-002 SHALL have parameter REG_BITS, default 8, width of register addresses.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to execute op on data_a/data_b; sampled on posedge clk.
REQ-006 SHALL have port op  input  3  operation select (encoding in REQ-012).
REQ-007 SHALL have port data_a  input  BITS  operand A, driven by reg_bank data_a.
REQ-008 SHALL have port data_b  input  BITS  operand B, driven by reg_bank data_b.
REQ-009 SHALL have port dest_address  input  REG_BITS  destination register of the result.
REQ-010 SHALL have ports write_enable (output, 1), write_address (output, REG_BITS) and write_data (output, BITS): writeback to reg_bank.
REQ-011 SHALL have ports busy (output, 1), multi-cycle op in progress, and zero (output, 1), last written result equal to 0.

Function
REQ-012 SHALL decode op as: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SLTU (1 if a<b unsigned, else 0), 110 MUL, 111 NOP.
REQ-013 SHALL compute ADD, SUB and MUL modulo 2^BITS; MUL result is the low BITS bits of the unsigned product; carries and overflow are discarded.
REQ-014 SHALL implement a state machine with states IDLE and MUL; start is accepted only in IDLE.
REQ-015 SHALL register all outputs; no output depends combinationally on any input.
REQ-016 On an edge with start=1 in IDLE and op in 000-101: write_enable<=1, write_data<=result, write_address<=dest_address; state stays IDLE (latency 1 cycle).
REQ-017 SHALL accept back-to-back single-cycle starts on consecutive edges, producing one write_enable cycle per start.
REQ-018 On an edge with start=1 in IDLE and op=111: no writeback, no state change, zero unchanged.
REQ-019 On an edge with start=1 in IDLE and op=110: latch data_a as multiplicand, data_b as multiplier, dest_address; clear accumulator and iteration counter; busy<=1; go to MUL.
REQ-020 Each edge in MUL: add multiplicand to accumulator if multiplier[0]=1; shift multiplicand left 1; shift multiplier right 1; increment counter.
REQ-021 On the BITS-th MUL edge: go to IDLE, busy<=0, write_enable<=1, write_data<=final accumulator, write_address<=latched dest_address; MUL latency is BITS cycles from the accepting edge.
REQ-022 SHALL ignore start, op, data_a, data_b and dest_address while in MUL; after MUL is accepted, operands are taken only from the latched copies.
REQ-023 SHALL accept a start on the same edge that busy falls (state is IDLE from that edge onward).
REQ-024 SHALL hold write_enable high for exactly one cycle per result and drive it to 0 on every edge that produces no result, so reg_bank read cycles resume.
REQ-025 SHALL update zero only on edges that set write_enable=1, to (result == 0); otherwise hold it.
REQ-026 SHALL hold write_data and write_address between writebacks.

Reset
REQ-027 SHALL, on any edge with rst=1, set state IDLE, write_enable=0, busy=0, zero=0, write_data=0, write_address=0, and clear accumulator, counter and latched operands.
REQ-028 rst SHALL take priority over start and over MUL progress; reset during MUL aborts the operation with no writeback.

Verification
REQ-029 BITS=8: start, op=000, a=0xF0, b=0x20, dest=3 -> next cycle write_enable=1 for 1 cycle, write_data=0x10, write_address=3, zero=0.
REQ-030 op=001, a=0x05, b=0x05 -> write_data=0x00, zero=1; then op=101, a=0x01, b=0xFF -> write_data=0x01, zero=0.
REQ-031 op=110, a=0x0D, b=0x0B, dest=7 -> busy high 8 cycles, write_enable exactly once, 8 cycles after accepting edge, write_data=0x8F, write_address=7.
REQ-032 MUL in progress; drive start with op=000 and changed operands/dest mid-operation -> ignored; MUL result and address unchanged; new start on busy-falling edge accepted, writeback 1 cycle later.
REQ-033 rst=1 on the 4th MUL cycle -> busy=0, write_enable=0 next cycle, no writeback ever for the aborted MUL.
REQ-034 Three consecutive starts (ADD, NOP, XOR a=0xAA b=0xFF) -> write_enable pattern 1,0,1; second result 0x55.
